fma16_rr_sched: RTL

Round-robin scheduler that shares one half-precision FMA datapath (fixed-latency fma16 multiply/add unit) between NREQ requesters. It accepts operand triples over valid/ready handshakes and issues at most one operation per cycle to the datapath. A per-issue tag pipeline tracks the owner of each in-flight operation. Results return to the owning requester through a one-entry result buffer per requester.

---
 rtl/fma16_rr_sched_if.sv | 44 ++++
 rtl/fma16_rr_sched.sv | 115 +++++++++++
 2 files changed

// File: rtl/fma16_rr_sched_if.sv
// Handshake bundle for the shared fma16 scheduler: requester operand channels,
// per-requester result channels and the issue/return path to the datapath.
// The slave modport is the scheduler's view; master is the requesters+datapath.
interface fma16_rr_sched_if #(
    parameter int NREQ = 2
);
    logic [NREQ-1:0]      req_valid;
    logic [NREQ-1:0]      req_ready;
    logic [16*NREQ-1:0]   req_x;
    logic [16*NREQ-1:0]   req_y;
    logic [16*NREQ-1:0]   req_z;
    logic [NREQ-1:0]      req_mul;
    logic [NREQ-1:0]      req_add;

    logic                 fma_valid;
    logic [15:0]          fma_x;
    logic [15:0]          fma_y;
    logic [15:0]          fma_z;
    logic                 fma_mul;
    logic                 fma_add;
    logic [15:0]          fma_result;

    logic [NREQ-1:0]      resp_valid;
    logic [NREQ-1:0]      resp_ready;
    logic [16*NREQ-1:0]   resp_result;

    modport slave (
        input  req_valid, req_x, req_y, req_z, req_mul, req_add,
        output req_ready,
        output fma_valid, fma_x, fma_y, fma_z, fma_mul, fma_add,
        input  fma_result,
        output resp_valid, resp_result,
        input  resp_ready
    );

    modport master (
        output req_valid, req_x, req_y, req_z, req_mul, req_add,
        input  req_ready,
        input  fma_valid, fma_x, fma_y, fma_z, fma_mul, fma_add,
        output fma_result,
        input  resp_valid, resp_result,
        output resp_ready
    );
endinterface

// File: rtl/fma16_rr_sched.sv
// Round-robin scheduler sharing one fixed-latency fma16 datapath among NREQ
// requesters. A tag pipeline mirrors the datapath latency so each returning
// result is written into its owner's one-entry result buffer.
module fma16_rr_sched #(
    parameter int NREQ = 2,
    parameter int LAT  = 2
) (
    input  logic               clk,
    input  logic               reset_n,
    fma16_rr_sched_if.slave    bus,
    output logic               busy
);
    localparam int IDW = $clog2(NREQ);

    typedef struct packed {
        logic           valid;
        logic [IDW-1:0] id;
    } tag_t;

    logic [IDW-1:0] ptr;
    logic [NREQ-1:0] pending;
    logic [NREQ-1:0] resp_valid;
    logic [NREQ-1:0] eligible;
    logic [15:0]    resp_data [NREQ];
    tag_t           tag_pipe [LAT];
    tag_t           done;
    logic           grant_hit;
    logic [IDW-1:0] grant_id;

    // A requester may hold at most one op, either in flight or buffered.
    assign eligible = bus.req_valid & ~pending & ~resp_valid;
    assign done     = tag_pipe[LAT-1];
    assign busy     = (|pending) | (|resp_valid);

    // Rotating-priority search: first eligible index starting at ptr.
    always_comb begin
        logic [IDW-1:0] idx;
        // NOTE: every output of a combinational block gets a default before any
        // branch; a path that leaves it unassigned would infer a latch.
        idx       = '0;
        grant_hit = 1'b0;
        grant_id  = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx = IDW'((int'(ptr) + k) % NREQ);
            if (!grant_hit && eligible[idx]) begin
                grant_hit = 1'b1;
                grant_id  = idx;
            end
        end
        if (!reset_n) grant_hit = 1'b0;
    end

    // Issue path: ready to the winner and operands muxed onto the datapath.
    always_comb begin
        bus.req_ready = '0;
        bus.fma_valid = grant_hit;
        bus.fma_x     = '0;
        bus.fma_y     = '0;
        bus.fma_z     = '0;
        bus.fma_mul   = 1'b0;
        bus.fma_add   = 1'b0;
        if (grant_hit) begin
            bus.req_ready[grant_id] = 1'b1;
            bus.fma_x   = bus.req_x[int'(grant_id)*16 +: 16];
            bus.fma_y   = bus.req_y[int'(grant_id)*16 +: 16];
            bus.fma_z   = bus.req_z[int'(grant_id)*16 +: 16];
            bus.fma_mul = bus.req_mul[grant_id];
            bus.fma_add = bus.req_add[grant_id];
        end
    end

    // Pack the per-requester result buffers onto the response bus.
    always_comb begin
        bus.resp_valid  = resp_valid;
        bus.resp_result = '0;
        for (int i = 0; i < NREQ; i++) begin
            bus.resp_result[i*16 +: 16] = resp_data[i];
        end
    end

    // Pointer, tag pipeline and per-requester pending/result state.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples pre-edge values regardless of statement order.
        if (!reset_n) begin
            ptr        <= '0;
            pending    <= '0;
            resp_valid <= '0;
            // NOTE: the result buffers are few and must read zero after reset,
            // so they are flops with reset rather than a RAM.
            for (int i = 0; i < NREQ; i++) resp_data[i] <= '0;
            for (int s = 0; s < LAT; s++)  tag_pipe[s] <= '0;
        end else begin
            if (grant_hit) begin
                ptr <= (int'(grant_id) == NREQ - 1) ? '0 : grant_id + 1'b1;
            end

            // The datapath never stalls, so tags advance every cycle.
            tag_pipe[0] <= {grant_hit, grant_id};
            for (int s = 1; s < LAT; s++) tag_pipe[s] <= tag_pipe[s-1];

            // Grant, completion and consumption on one requester are mutually
            // exclusive because pending and resp_valid never overlap.
            for (int i = 0; i < NREQ; i++) begin
                if (grant_hit && int'(grant_id) == i) pending[i] <= 1'b1;
                if (done.valid && int'(done.id) == i) begin
                    pending[i]    <= 1'b0;
                    resp_valid[i] <= 1'b1;
                    resp_data[i]  <= bus.fma_result;
                end
                if (resp_valid[i] && bus.resp_ready[i]) resp_valid[i] <= 1'b0;
            end
        end
    end
endmodule
